mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the 5-stage pipeline. Sits directly downstream of alu_mem_buff and consumes its registered outputs: Mem/WB control, PC, Rdst, ALU result, read_data1 and flags.
- Owns the data/stack memory and the stack pointer (SP).
- Executes load, store, push and pop. Executes 32-bit PC push/pop for call/int/ret/rti as multi-cycle operations, stalling upstream.
- Drives the registered inputs of the mem/wb buffer.

Parameters:
- ADDR_W, 12: word-address width; memory depth is 2^ADDR_W words of 16 bits.
- SP_INIT, 2^ADDR_W-1 (all ones): SP value after reset.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- i_Mem  in  6  control bits: [5] mem_read, [4] mem_write, [3] sp_en, [2] wide, [1] addr_sel (0 = ALU address, 1 = SP), [0] int_flag
- i_WB  in  4  writeback control, passed through
- i_pc  in  32  PC to push (wide write)
- i_Rdst  in  3  destination register, passed through
- i_alu  in  16  ALU result; address when addr_sel=0
- i_read_data1  in  16  store/push data
- i_flag  in  4  current CCR flags
- stall  out  1  combinational; holds alu_mem_buff and earlier stages
- o_WB  out  4  registered WB control
- o_Rdst  out  3  registered
- o_alu  out  16  registered ALU result
- o_mem_data  out  16  registered load/pop data
- o_pc  out  32  registered popped PC
- o_pc_valid  out  1  one-cycle pulse when o_pc is valid
- o_flag  out  4  registered restored flags
- o_flag_valid  out  1  one-cycle pulse (FLAG_SAVE_EN only)
- o_sp  out  ADDR_W  current SP, for debug and verification

Behaviour:
- Reset (synchronous): SP=SP_INIT, FSM=IDLE. All o_* outputs are 0, stall=0. Memory contents are not cleared.
- Address: addr_sel=0 -> i_alu[ADDR_W-1:0]; addr_sel=1 -> SP as described below.
- Write/read priority: mem_write takes priority over mem_read; if both are set, the access is a write only.
- Memory write is synchronous. Memory read is combinational from the array and captured into o_mem_data at the edge. Load-to-o_mem_data latency is 1 cycle.
- Push (write, sp_en, !wide): mem[SP] <= i_read_data1; SP <= SP-1.
- Pop (read, sp_en, !wide): o_mem_data <= mem[SP+1]; SP <= SP+1.
- SP arithmetic is modulo 2^ADDR_W and wraps silently: push at SP=0 -> SP=all ones; pop at all ones -> 0.
- Non-SP load/store leaves SP unchanged.
- FSM states: IDLE, W1, W2, W3 (W3 exists only with FLAG_SAVE_EN).
- Wide write, starting from SP=S (no flag save):
  - IDLE: mem[S] <= i_pc[31:16]; SP <= S-1; go to W1; stall=1.
  - W1: mem[S-1] <= i_pc[15:0]; SP <= S-2; go to IDLE; stall=0.
- Wide read, starting from SP=S-2:
  - IDLE: capture mem[S-1] as low half; SP <= S-1; go to W1; stall=1.
  - W1: o_pc <= {mem[S], low}; SP <= S; o_pc_valid=1 next cycle; go to IDLE.
- Upstream inputs are guaranteed stable while stall=1.
- Writeback gating: in every cycle where stall=1, the registered o_WB is forced to 0, so no duplicate writeback occurs. The final cycle of the operation registers i_WB.
- Pass-through: o_Rdst and o_alu always register their inputs; 1-cycle latency.
- Reset mid-operation: FSM returns to IDLE and SP=SP_INIT. A partially pushed word stays in memory. No o_pc_valid is produced.
- Pulses: o_pc_valid and o_flag_valid are high for exactly one cycle, otherwise 0.

Optional Feature:
- Macro: FLAG_SAVE_EN.
- Defined, wide write with int_flag=1: 3 cycles.
  - mem[S] <= {12'b0, i_flag}
  - then high half of i_pc, then low half
  - SP ends at S-3; stall is high for the first 2 cycles.
- Defined, wide read with int_flag=1: pops low, high, then flags (3 cycles). o_pc_valid and o_flag_valid pulse together, and o_flag <= mem[S][3:0].
- Not defined: int_flag is ignored; W3, o_flag_valid and the flag save are absent. o_flag and o_flag_valid are tied to 0.

Test Plan:
1. Reset, then push i_read_data1=0xBEEF -> mem[4095]=0xBEEF, o_sp=4094; then pop -> o_mem_data=0xBEEF next cycle, o_sp=4095.
2. Store 0x1234 at i_alu=0x0010, then load address 0x0010 -> o_mem_data=0x1234; o_sp stays 4095 throughout.
3. Call with i_pc=0x0001_0200 -> stall high 1 cycle, mem[4095]=0x0001, mem[4094]=0x0200, o_sp=4093, o_WB=0 in the stall cycle. Then ret -> o_pc=0x00010200 with a one-cycle o_pc_valid, o_sp=4095.
4. Pop at SP=4095 -> SP wraps to 0, reads mem[0]; push at SP=0 -> writes mem[0], SP=4095.
5. rst asserted in W1 of a call -> next cycle FSM=IDLE, o_sp=4095, stall=0, o_pc_valid never pulses.
6. (FLAG_SAVE_EN) int with i_flag=4'b1010, i_pc=0x00000020 -> mem[4095]=0x000A, o_sp=4092. rti -> o_pc=0x20, o_flag=4'b1010, both valid pulses in the same cycle.

Source files
------------

// File: rtl/mem_stage_if.sv
// Bus between alu_mem_buff (upstream), mem_stage and the mem/wb buffer.
// The slave modport is the mem_stage side; the master modport drives the stage.
interface mem_stage_if #(
    parameter int ADDR_W = 12
);
    logic [5:0]        i_Mem;
    logic [3:0]        i_WB;
    logic [31:0]       i_pc;
    logic [2:0]        i_Rdst;
    logic [15:0]       i_alu;
    logic [15:0]       i_read_data1;
    logic [3:0]        i_flag;
    logic              stall;
    logic [3:0]        o_WB;
    logic [2:0]        o_Rdst;
    logic [15:0]       o_alu;
    logic [15:0]       o_mem_data;
    logic [31:0]       o_pc;
    logic              o_pc_valid;
    logic [3:0]        o_flag;
    logic              o_flag_valid;
    logic [ADDR_W-1:0] o_sp;

    modport master (
        output i_Mem, i_WB, i_pc, i_Rdst, i_alu, i_read_data1, i_flag,
        input  stall, o_WB, o_Rdst, o_alu, o_mem_data, o_pc, o_pc_valid,
               o_flag, o_flag_valid, o_sp
    );

    modport slave (
        input  i_Mem, i_WB, i_pc, i_Rdst, i_alu, i_read_data1, i_flag,
        output stall, o_WB, o_Rdst, o_alu, o_mem_data, o_pc, o_pc_valid,
               o_flag, o_flag_valid, o_sp
    );
endinterface

// File: rtl/mem_stage.sv
// Memory stage: data/stack memory, stack pointer, and multi-cycle 32-bit PC push/pop.
// Optional FLAG_SAVE_EN adds a CCR flag word to wide push/pop when int_flag is set.
module mem_stage #(
    parameter int              ADDR_W  = 12,
    parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
    input  logic        clk,
    input  logic        rst,
    mem_stage_if.slave  bus
);
    // state | meaning
    // IDLE  | single-cycle ops; first cycle of a wide op
    // W1    | wide write: low PC half; wide read: high PC half, PC done
    // W2    | wide read with flags: high PC half
    // W3    | wide write with flags: high PC half; wide read with flags: flags, PC done
`ifdef FLAG_SAVE_EN
    typedef enum logic [1:0] {IDLE, W1, W2, W3} state_t;
`else
    typedef enum logic [1:0] {IDLE, W1, W2} state_t;
`endif

    state_t            r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_sp;
    logic [15:0]       r_mem [0:(1<<ADDR_W)-1];
    logic [15:0]       r_low, r_high;
    logic [3:0]        r_WB;
    logic [2:0]        r_Rdst;
    logic [15:0]       r_alu, r_mem_data;
    logic [31:0]       r_pc;
    logic              r_pc_valid;

    logic              w_rd, w_wr, w_sp_en, w_wide, w_sel, w_flag_op;
    logic [ADDR_W-1:0] w_sp_inc, w_sp_dec, w_sp_nxt, w_waddr, w_raddr;
    logic [15:0]       w_wdata, w_rdata;
    logic [31:0]       w_pc_nxt;
    logic              w_we, w_stall, w_ld, w_cap_low, w_cap_high, w_pc_done, w_flag_done;

    assign w_wr     = bus.i_Mem[4];
    assign w_rd     = bus.i_Mem[5] & ~bus.i_Mem[4];
    assign w_sp_en  = bus.i_Mem[3];
    assign w_wide   = bus.i_Mem[2];
    assign w_sel    = bus.i_Mem[1];
`ifdef FLAG_SAVE_EN
    assign w_flag_op = bus.i_Mem[0];
`else
    logic w_unused;
    assign w_flag_op = 1'b0;
    assign w_unused  = ^{bus.i_Mem[0], bus.i_flag};
`endif

    assign w_sp_inc = r_sp + 1'b1;
    assign w_sp_dec = r_sp - 1'b1;
    // Pops read one above SP; only a plain non-SP load uses the ALU address.
    assign w_raddr  = (r_state == IDLE && !w_wide && !w_sel) ? bus.i_alu[ADDR_W-1:0] : w_sp_inc;
    assign w_rdata  = r_mem[w_raddr];

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = IDLE;
        case (r_state)
            IDLE: begin
                if (w_wide && w_wr)      w_state_nxt = w_flag_op ? state_t'(2'd3) : W1;
                else if (w_wide && w_rd) w_state_nxt = w_flag_op ? W2 : W1;
                else                     w_state_nxt = IDLE;
            end
            W1: w_state_nxt = IDLE;
`ifdef FLAG_SAVE_EN
            W2: w_state_nxt = W3;
            W3: w_state_nxt = w_wr ? W1 : IDLE;
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_we        = 1'b0;
        w_waddr     = r_sp;
        w_wdata     = bus.i_read_data1;
        w_sp_nxt    = r_sp;
        w_stall     = 1'b0;
        w_ld        = 1'b0;
        w_cap_low   = 1'b0;
        w_cap_high  = 1'b0;
        w_pc_done   = 1'b0;
        w_flag_done = 1'b0;
        w_pc_nxt    = {w_rdata, r_low};
        case (r_state)
            IDLE: begin
                if (w_wr && w_wide) begin
                    w_we     = 1'b1;
                    w_wdata  = w_flag_op ? {12'b0, bus.i_flag} : bus.i_pc[31:16];
                    w_sp_nxt = w_sp_dec;
                    w_stall  = 1'b1;
                end else if (w_wr) begin
                    w_we    = 1'b1;
                    w_waddr = w_sel ? r_sp : bus.i_alu[ADDR_W-1:0];
                    if (w_sp_en) w_sp_nxt = w_sp_dec;
                end else if (w_rd && w_wide) begin
                    w_cap_low = 1'b1;
                    w_sp_nxt  = w_sp_inc;
                    w_stall   = 1'b1;
                end else if (w_rd) begin
                    w_ld = 1'b1;
                    if (w_sp_en) w_sp_nxt = w_sp_inc;
                end
            end
            W1: begin
                if (w_wr) begin
                    w_we     = 1'b1;
                    w_wdata  = bus.i_pc[15:0];
                    w_sp_nxt = w_sp_dec;
                end else begin
                    w_pc_done = 1'b1;
                    w_sp_nxt  = w_sp_inc;
                end
            end
`ifdef FLAG_SAVE_EN
            W2: begin
                w_cap_high = 1'b1;
                w_sp_nxt   = w_sp_inc;
                w_stall    = 1'b1;
            end
            W3: begin
                if (w_wr) begin
                    w_we     = 1'b1;
                    w_wdata  = bus.i_pc[31:16];
                    w_sp_nxt = w_sp_dec;
                    w_stall  = 1'b1;
                end else begin
                    w_pc_done   = 1'b1;
                    w_flag_done = 1'b1;
                    w_pc_nxt    = {r_high, r_low};
                    w_sp_nxt    = w_sp_inc;
                end
            end
`endif
            default: ;
        endcase
        if (rst) begin
            w_we    = 1'b0;
            w_stall = 1'b0;
        end
    end

    // Memory is never reset; contents survive a mid-operation reset.
    always_ff @(posedge clk) begin
        if (w_we) r_mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sp       <= SP_INIT;
            r_low      <= '0;
            r_high     <= '0;
            r_WB       <= '0;
            r_Rdst     <= '0;
            r_alu      <= '0;
            r_mem_data <= '0;
            r_pc       <= '0;
            r_pc_valid <= 1'b0;
        end else begin
            r_sp       <= w_sp_nxt;
            r_WB       <= w_stall ? 4'b0 : bus.i_WB;
            r_Rdst     <= bus.i_Rdst;
            r_alu      <= bus.i_alu;
            r_pc_valid <= w_pc_done;
            if (w_ld)       r_mem_data <= w_rdata;
            if (w_cap_low)  r_low      <= w_rdata;
            if (w_cap_high) r_high     <= w_rdata;
            if (w_pc_done)  r_pc       <= w_pc_nxt;
        end
    end

`ifdef FLAG_SAVE_EN
    logic [3:0] r_flag;
    logic       r_flag_valid;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flag       <= '0;
            r_flag_valid <= 1'b0;
        end else begin
            r_flag_valid <= w_flag_done;
            if (w_flag_done) r_flag <= w_rdata[3:0];
        end
    end
    assign bus.o_flag       = r_flag;
    assign bus.o_flag_valid = r_flag_valid;
`else
    assign bus.o_flag       = 4'b0;
    assign bus.o_flag_valid = 1'b0;
`endif

    assign bus.stall      = w_stall;
    assign bus.o_WB       = r_WB;
    assign bus.o_Rdst     = r_Rdst;
    assign bus.o_alu      = r_alu;
    assign bus.o_mem_data = r_mem_data;
    assign bus.o_pc       = r_pc;
    assign bus.o_pc_valid = r_pc_valid;
    assign bus.o_sp       = r_sp;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: table of single-cycle ops, then hand-written
// call/ret, mid-operation reset and (with FLAG_SAVE_EN) int/rti sequences.
module tb_mem_stage;
    localparam logic [5:0] M_NOP  = 6'b000000;
    localparam logic [5:0] M_LD   = 6'b100000;
    localparam logic [5:0] M_ST   = 6'b010000;
    localparam logic [5:0] M_RW   = 6'b110000;
    localparam logic [5:0] M_PUSH = 6'b011010;
    localparam logic [5:0] M_POP  = 6'b101010;
    localparam logic [5:0] M_CALL = 6'b011110;
    localparam logic [5:0] M_RET  = 6'b101110;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;

    mem_stage_if #(.ADDR_W(12)) bus_if ();

    mem_stage #(.ADDR_W(12)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  mem;
        logic [3:0]  wb;
        logic [15:0] alu;
        logic [15:0] rd1;
        logic [2:0]  rdst;
        logic [15:0] exp_md;
        logic [11:0] exp_sp;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [5:0] m, input logic [3:0] wb, input logic [15:0] alu,
                         input logic [15:0] rd1, input logic [2:0] rdst,
                         input logic [31:0] pc, input logic [3:0] flag);
        bus_if.i_Mem        = m;
        bus_if.i_WB         = wb;
        bus_if.i_alu        = alu;
        bus_if.i_read_data1 = rd1;
        bus_if.i_Rdst       = rdst;
        bus_if.i_pc         = pc;
        bus_if.i_flag       = flag;
    endtask

    task automatic load_chk(input string name, input logic [15:0] addr, input logic [15:0] exp);
        drive(M_LD, 4'h0, addr, 16'h0, 3'd0, 32'h0, 4'h0);
        tick();
        chk(name, {16'h0, bus_if.o_mem_data}, {16'h0, exp});
    endtask

    initial begin
        vecs[0]  = '{M_PUSH, 4'h3, 16'h0AAA, 16'hBEEF, 3'd1, 16'h0000, 12'd4094};
        vecs[1]  = '{M_POP,  4'h5, 16'h0BBB, 16'h0000, 3'd2, 16'hBEEF, 12'd4095};
        vecs[2]  = '{M_ST,   4'h0, 16'h0010, 16'h1234, 3'd3, 16'hBEEF, 12'd4095};
        vecs[3]  = '{M_LD,   4'h9, 16'h0010, 16'h0000, 3'd4, 16'h1234, 12'd4095};
        vecs[4]  = '{M_ST,   4'h1, 16'h0000, 16'h5555, 3'd5, 16'h1234, 12'd4095};
        vecs[5]  = '{M_POP,  4'h2, 16'h0CCC, 16'h0000, 3'd6, 16'h5555, 12'd0};
        vecs[6]  = '{M_PUSH, 4'h4, 16'h0DDD, 16'h7777, 3'd7, 16'h5555, 12'd4095};
        vecs[7]  = '{M_LD,   4'h6, 16'h0000, 16'h0000, 3'd0, 16'h7777, 12'd4095};
        vecs[8]  = '{M_LD,   4'h7, 16'h0FFF, 16'h0000, 3'd1, 16'hBEEF, 12'd4095};
        vecs[9]  = '{M_RW,   4'h8, 16'h0020, 16'hA5A5, 3'd2, 16'hBEEF, 12'd4095};
        vecs[10] = '{M_LD,   4'hA, 16'h0020, 16'h0000, 3'd3, 16'hA5A5, 12'd4095};
        vecs[11] = '{M_LD,   4'hB, 16'hF020, 16'h0000, 3'd4, 16'hA5A5, 12'd4095};

        rst = 1'b1;
        drive(M_NOP, 4'hF, 16'hFFFF, 16'hFFFF, 3'd7, 32'hFFFF_FFFF, 4'hF);
        tick();
        tick();
        chk("rst_sp",       32'(bus_if.o_sp), 32'd4095);
        chk("rst_stall",    32'(bus_if.stall), 32'd0);
        chk("rst_wb",       32'(bus_if.o_WB), 32'd0);
        chk("rst_alu",      32'(bus_if.o_alu), 32'd0);
        chk("rst_md",       32'(bus_if.o_mem_data), 32'd0);
        chk("rst_pc",       bus_if.o_pc, 32'd0);
        chk("rst_pc_valid", 32'(bus_if.o_pc_valid), 32'd0);
        chk("rst_flag",     32'({bus_if.o_flag_valid, bus_if.o_flag}), 32'd0);
        rst = 1'b0;
        drive(M_NOP, 4'h0, 16'h0, 16'h0, 3'd0, 32'h0, 4'h0);
        tick();

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].mem, vecs[i].wb, vecs[i].alu, vecs[i].rd1, vecs[i].rdst, 32'h0, 4'h0);
            #1;
            chk($sformatf("v%0d_stall", i), 32'(bus_if.stall), 32'd0);
            tick();
            chk($sformatf("v%0d_wb", i),   32'(bus_if.o_WB), 32'(vecs[i].wb));
            chk($sformatf("v%0d_alu", i),  32'(bus_if.o_alu), 32'(vecs[i].alu));
            chk($sformatf("v%0d_rdst", i), 32'(bus_if.o_Rdst), 32'(vecs[i].rdst));
            chk($sformatf("v%0d_md", i),   32'(bus_if.o_mem_data), 32'(vecs[i].exp_md));
            chk($sformatf("v%0d_sp", i),   32'(bus_if.o_sp), 32'(vecs[i].exp_sp));
            chk($sformatf("v%0d_pcv", i),  32'(bus_if.o_pc_valid), 32'd0);
        end

        // call: two-cycle PC push; int_flag set only matters with flag save enabled
        drive(M_CALL, 4'hF, 16'h0, 16'h0, 3'd0, 32'h0001_0200, 4'h0);
        #1;
        chk("call_stall0", 32'(bus_if.stall), 32'd1);
        tick();
        chk("call_wb0",    32'(bus_if.o_WB), 32'd0);
        chk("call_sp0",    32'(bus_if.o_sp), 32'd4094);
        chk("call_stall1", 32'(bus_if.stall), 32'd0);
        tick();
        chk("call_wb1",    32'(bus_if.o_WB), 32'hF);
        chk("call_sp1",    32'(bus_if.o_sp), 32'd4093);
        load_chk("call_hi", 16'h0FFF, 16'h0001);
        load_chk("call_lo", 16'h0FFE, 16'h0200);

        drive(M_RET, 4'hC, 16'h0, 16'h0, 3'd0, 32'h0, 4'h0);
        #1;
        chk("ret_stall0", 32'(bus_if.stall), 32'd1);
        tick();
        chk("ret_wb0",    32'(bus_if.o_WB), 32'd0);
        chk("ret_sp0",    32'(bus_if.o_sp), 32'd4094);
        chk("ret_pcv0",   32'(bus_if.o_pc_valid), 32'd0);
        chk("ret_stall1", 32'(bus_if.stall), 32'd0);
        tick();
        chk("ret_pc",     bus_if.o_pc, 32'h0001_0200);
        chk("ret_pcv1",   32'(bus_if.o_pc_valid), 32'd1);
        chk("ret_wb1",    32'(bus_if.o_WB), 32'hC);
        chk("ret_sp1",    32'(bus_if.o_sp), 32'd4095);
        drive(M_NOP, 4'h0, 16'h0, 16'h0, 3'd0, 32'h0, 4'h0);
        tick();
        chk("ret_pcv2",   32'(bus_if.o_pc_valid), 32'd0);

        // reset while in W1 of a call
        drive(M_CALL, 4'h7, 16'h0, 16'h0, 3'd0, 32'hDEAD_BEEF, 4'h0);
        tick();
        chk("rcall_sp0", 32'(bus_if.o_sp), 32'd4094);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(M_NOP, 4'h0, 16'h0, 16'h0, 3'd0, 32'h0, 4'h0);
        #1;
        chk("rcall_sp",    32'(bus_if.o_sp), 32'd4095);
        chk("rcall_stall", 32'(bus_if.stall), 32'd0);
        chk("rcall_wb",    32'(bus_if.o_WB), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("rcall_pcv%0d", i), 32'(bus_if.o_pc_valid), 32'd0);
        end
        load_chk("rcall_hi", 16'h0FFF, 16'hDEAD);
        chk("rcall_sp_end", 32'(bus_if.o_sp), 32'd4095);

`ifdef FLAG_SAVE_EN
        drive(M_CALL | 6'b1, 4'h5, 16'h0, 16'h0, 3'd0, 32'h0000_0020, 4'b1010);
        #1;
        chk("int_stall0", 32'(bus_if.stall), 32'd1);
        tick();
        chk("int_sp0",    32'(bus_if.o_sp), 32'd4094);
        chk("int_wb0",    32'(bus_if.o_WB), 32'd0);
        chk("int_stall1", 32'(bus_if.stall), 32'd1);
        tick();
        chk("int_sp1",    32'(bus_if.o_sp), 32'd4093);
        chk("int_wb1",    32'(bus_if.o_WB), 32'd0);
        chk("int_stall2", 32'(bus_if.stall), 32'd0);
        tick();
        chk("int_sp2",    32'(bus_if.o_sp), 32'd4092);
        chk("int_wb2",    32'(bus_if.o_WB), 32'h5);
        load_chk("int_flagw", 16'h0FFF, 16'h000A);
        load_chk("int_hi",    16'h0FFE, 16'h0000);
        load_chk("int_lo",    16'h0FFD, 16'h0020);

        drive(M_RET | 6'b1, 4'h6, 16'h0, 16'h0, 3'd0, 32'h0, 4'h0);
        #1;
        chk("rti_stall0", 32'(bus_if.stall), 32'd1);
        tick();
        chk("rti_stall1", 32'(bus_if.stall), 32'd1);
        chk("rti_pcv0",   32'(bus_if.o_pc_valid), 32'd0);
        tick();
        chk("rti_stall2", 32'(bus_if.stall), 32'd0);
        chk("rti_fv0",    32'(bus_if.o_flag_valid), 32'd0);
        tick();
        chk("rti_pc",     bus_if.o_pc, 32'h0000_0020);
        chk("rti_flag",   32'(bus_if.o_flag), 32'hA);
        chk("rti_pcv",    32'(bus_if.o_pc_valid), 32'd1);
        chk("rti_fv",     32'(bus_if.o_flag_valid), 32'd1);
        chk("rti_sp",     32'(bus_if.o_sp), 32'd4095);
        chk("rti_wb",     32'(bus_if.o_WB), 32'h6);
        drive(M_NOP, 4'h0, 16'h0, 16'h0, 3'd0, 32'h0, 4'h0);
        tick();
        chk("rti_pulse_end", 32'({bus_if.o_pc_valid, bus_if.o_flag_valid}), 32'd0);
`else
        // int_flag is ignored: behaves as a plain two-cycle call/ret
        drive(M_CALL | 6'b1, 4'h5, 16'h0, 16'h0, 3'd0, 32'h0000_0020, 4'b1010);
        #1;
        chk("int_stall0", 32'(bus_if.stall), 32'd1);
        tick();
        chk("int_stall1", 32'(bus_if.stall), 32'd0);
        tick();
        chk("int_sp",     32'(bus_if.o_sp), 32'd4093);
        load_chk("int_hi", 16'h0FFF, 16'h0000);
        load_chk("int_lo", 16'h0FFE, 16'h0020);
        drive(M_RET | 6'b1, 4'h6, 16'h0, 16'h0, 3'd0, 32'h0, 4'h0);
        tick();
        tick();
        chk("rti_pc",  bus_if.o_pc, 32'h0000_0020);
        chk("rti_pcv", 32'(bus_if.o_pc_valid), 32'd1);
        chk("rti_sp",  32'(bus_if.o_sp), 32'd4095);
        chk("rti_flag_tied", 32'({bus_if.o_flag_valid, bus_if.o_flag}), 32'd0);
        drive(M_NOP, 4'h0, 16'h0, 16'h0, 3'd0, 32'h0, 4'h0);
        tick();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
